// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for alu_arbiter and its ALU.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority for port 0.
package alu_arbiter_pkg;

   localparam logic [2:0] ALU_ADD_SUB = 3'd0;
   localparam logic [2:0] ALU_SLL     = 3'd1;
   localparam logic [2:0] ALU_SLT     = 3'd2;
   localparam logic [2:0] ALU_SLTU    = 3'd3;
   localparam logic [2:0] ALU_XOR     = 3'd4;
   localparam logic [2:0] ALU_SRL_SRA = 3'd5;
   localparam logic [2:0] ALU_OR      = 3'd6;
   localparam logic [2:0] ALU_AND_CLR = 3'd7;

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   typedef struct packed {
      logic [2:0]  function_select;
      logic        function_modifier;
      logic [31:0] input_a;
      logic [31:0] input_b;
   } alu_op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by the arbiter ports.
// Modifier selects SUB, SRA or CLR (~a & b) on the matching ops.
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
(
   input  logic [2:0]  function_select,
   input  logic        function_modifier,
   input  logic [31:0] input_a,
   input  logic [31:0] input_b,
   output logic [31:0] result
);

   logic [4:0]  shamt;
   logic [31:0] sra;

   assign shamt = input_b[4:0];
   assign sra   = $signed(input_a) >>> shamt;

   always_comb begin
      result = '0;
      unique case (function_select)
         ALU_ADD_SUB: begin
            if (function_modifier)
               result = input_a - input_b;
            else
               result = input_a + input_b;
         end
         ALU_SLL:  result = input_a << shamt;
         ALU_SLT:
            result = {31'd0, $signed(input_a) < $signed(input_b)};
         ALU_SLTU: result = {31'd0, input_a < input_b};
         ALU_XOR:  result = input_a ^ input_b;
         ALU_SRL_SRA: begin
            if (function_modifier)
               result = sra;
            else
               result = input_a >> shamt;
         end
         ALU_OR:   result = input_a | input_b;
         ALU_AND_CLR: begin
            if (function_modifier)
               result = ~input_a & input_b;
            else
               result = input_a & input_b;
         end
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter around one ALU with a one-entry result buffer.
// Define ALU_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [2:0]           req0_function_select,
   input  logic                 req0_function_modifier,
   input  logic [31:0]          req0_input_a,
   input  logic [31:0]          req0_input_b,
   input  logic [TAG_WIDTH-1:0] req0_tag,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [2:0]           req1_function_select,
   input  logic                 req1_function_modifier,
   input  logic [31:0]          req1_input_a,
   input  logic [31:0]          req1_input_b,
   input  logic [TAG_WIDTH-1:0] req1_tag,
   output logic                 rsp0_valid,
   input  logic                 rsp0_ready,
   output logic [31:0]          rsp0_result,
   output logic [TAG_WIDTH-1:0] rsp0_tag,
   output logic                 rsp1_valid,
   input  logic                 rsp1_ready,
   output logic [31:0]          rsp1_result,
   output logic [TAG_WIDTH-1:0] rsp1_tag
);

   logic [0:0]           state;
   logic                 owner;
   logic [31:0]          buf_result;
   logic [TAG_WIDTH-1:0] buf_tag;

   logic                 consume;
   logic                 free;
   logic                 grant;
   logic                 accept;
   alu_op_t              op;
   logic [TAG_WIDTH-1:0] op_tag;
   logic [31:0]          alu_result;

   assign consume = (state == FULL) &&
                    (owner ? rsp1_ready : rsp0_ready);
   assign free    = (state == EMPTY) || consume;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign grant = !req0_valid && req1_valid;
`else
   logic last_grant;

   // On contention the port served last yields.
   assign grant = (req0_valid && req1_valid) ?
                  !last_grant : req1_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= grant;
   end
`endif

   assign req0_ready = free && !grant;
   assign req1_ready = free && grant;
   assign accept     = (req0_valid && req0_ready) ||
                       (req1_valid && req1_ready);

   always_comb begin
      if (grant) begin
         op.function_select   = req1_function_select;
         op.function_modifier = req1_function_modifier;
         op.input_a           = req1_input_a;
         op.input_b           = req1_input_b;
         op_tag               = req1_tag;
      end else begin
         op.function_select   = req0_function_select;
         op.function_modifier = req0_function_modifier;
         op.input_a           = req0_input_a;
         op.input_b           = req0_input_b;
         op_tag               = req0_tag;
      end
   end

   alu_arbiter_alu u_alu (
      .function_select   (op.function_select),
      .function_modifier (op.function_modifier),
      .input_a           (op.input_a),
      .input_b           (op.input_b),
      .result            (alu_result)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= EMPTY;
         owner      <= 1'b0;
         buf_result <= '0;
         buf_tag    <= '0;
      end else if (accept) begin
         state      <= FULL;
         owner      <= grant;
         buf_result <= alu_result;
         buf_tag    <= op_tag;
      end else if (consume) begin
         state      <= EMPTY;
      end
   end

   assign rsp0_valid  = (state == FULL) && !owner;
   assign rsp1_valid  = (state == FULL) && owner;
   assign rsp0_result = buf_result;
   assign rsp1_result = buf_result;
   assign rsp0_tag    = buf_tag;
   assign rsp1_tag    = buf_tag;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int TW = 4;

   logic          clk;
   logic          reset;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [2:0]    req0_function_select, req1_function_select;
   logic          req0_function_modifier, req1_function_modifier;
   logic [31:0]   req0_input_a, req0_input_b;
   logic [31:0]   req1_input_a, req1_input_b;
   logic [TW-1:0] req0_tag, req1_tag;
   logic          rsp0_valid, rsp1_valid;
   logic          rsp0_ready, rsp1_ready;
   logic [31:0]   rsp0_result, rsp1_result;
   logic [TW-1:0] rsp0_tag, rsp1_tag;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.TAG_WIDTH(TW)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .req0_valid             (req0_valid),
      .req0_ready             (req0_ready),
      .req0_function_select   (req0_function_select),
      .req0_function_modifier (req0_function_modifier),
      .req0_input_a           (req0_input_a),
      .req0_input_b           (req0_input_b),
      .req0_tag               (req0_tag),
      .req1_valid             (req1_valid),
      .req1_ready             (req1_ready),
      .req1_function_select   (req1_function_select),
      .req1_function_modifier (req1_function_modifier),
      .req1_input_a           (req1_input_a),
      .req1_input_b           (req1_input_b),
      .req1_tag               (req1_tag),
      .rsp0_valid             (rsp0_valid),
      .rsp0_ready             (rsp0_ready),
      .rsp0_result            (rsp0_result),
      .rsp0_tag               (rsp0_tag),
      .rsp1_valid             (rsp1_valid),
      .rsp1_ready             (rsp1_ready),
      .rsp1_result            (rsp1_result),
      .rsp1_tag               (rsp1_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]    f;
      logic          m;
      logic [31:0]   a;
      logic [31:0]   b;
      logic [TW-1:0] tag;
   } req_t;

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic        m;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   task automatic chk32(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act,
                       input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference ALU from arithmetic definitions on 64-bit integers.
   function automatic logic [31:0] ref_alu(input logic [2:0] f,
                                           input logic m,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint ua = {32'd0, a};
      longint ub = {32'd0, b};
      longint sa = {{32{a[31]}}, a};
      longint sb = {{32{b[31]}}, b};
      longint sh = ub % 32;
      longint p2 = 1;
      longint r  = 0;
      for (longint k = 0; k < sh; k++) p2 = p2 * 2;
      case (f)
         ALU_ADD_SUB: r = m ? ua - ub : ua + ub;
         ALU_SLL:     r = ua * p2;
         ALU_SLT:     r = (sa < sb) ? 1 : 0;
         ALU_SLTU:    r = (ua < ub) ? 1 : 0;
         ALU_XOR:     r = {32'd0, a ^ b};
         ALU_SRL_SRA: begin
            if (m) begin
               r = sa / p2;
               if (sa < 0 && (sa % p2) != 0) r = r - 1;
            end else begin
               r = ua / p2;
            end
         end
         ALU_OR:      r = {32'd0, a | b};
         default:     r = {32'd0, m ? (~a & b) : (a & b)};
      endcase
      return r[31:0];
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] edges [4];
      edges[0] = 32'h0000_0000;
      edges[1] = 32'hFFFF_FFFF;
      edges[2] = 32'h8000_0000;
      edges[3] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0)
         return edges[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.f   = 3'($urandom_range(0, 7));
      r.m   = 1'($urandom_range(0, 1));
      r.a   = rand_word();
      r.b   = rand_word();
      r.tag = TW'($urandom_range(0, 15));
      return r;
   endfunction

   task automatic drive0(input logic v, input req_t r);
      req0_valid             = v;
      req0_function_select   = r.f;
      req0_function_modifier = r.m;
      req0_input_a           = r.a;
      req0_input_b           = r.b;
      req0_tag               = r.tag;
   endtask

   task automatic drive1(input logic v, input req_t r);
      req1_valid             = v;
      req1_function_select   = r.f;
      req1_function_modifier = r.m;
      req1_input_a           = r.a;
      req1_input_b           = r.b;
      req1_tag               = r.tag;
   endtask

   vec_t vecs [12];
   req_t idle, r0, r1;

   // Model state for the random phase.
   bit          m_full;
   bit          m_own;
   bit          m_last;
   logic [31:0] m_res;
   logic [TW-1:0] m_tag;

   initial begin
      bit exp_g, hold0, hold1, v0, v1, rr0, rr1;
      bit mfree, acc0, acc1;
      logic [31:0] xr;

      vecs[0]  = '{"add",     ALU_ADD_SUB, 1'b0, 32'd100, 32'd23, 32'd123};
      vecs[1]  = '{"add_wrap",ALU_ADD_SUB, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0};
      vecs[2]  = '{"sub",     ALU_ADD_SUB, 1'b1, 32'd0, 32'd1, 32'hFFFF_FFFF};
      vecs[3]  = '{"slt",     ALU_SLT,     1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1};
      vecs[4]  = '{"sltu",    ALU_SLTU,    1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0};
      vecs[5]  = '{"sll33",   ALU_SLL,     1'b0, 32'h0000_0001, 32'd33, 32'd2};
      vecs[6]  = '{"sra",     ALU_SRL_SRA, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000};
      vecs[7]  = '{"srl",     ALU_SRL_SRA, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000};
      vecs[8]  = '{"clr",     ALU_AND_CLR, 1'b1, 32'h0000_00F0, 32'hFF, 32'h0000_000F};
      vecs[9]  = '{"and",     ALU_AND_CLR, 1'b0, 32'h0000_00F0, 32'hFF, 32'h0000_00F0};
      vecs[10] = '{"xor",     ALU_XOR,     1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F};
      vecs[11] = '{"or",      ALU_OR,      1'b0, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};

      idle = '{3'd0, 1'b0, 32'd0, 32'd0, '0};
      reset = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      drive0(1'b0, idle);
      drive1(1'b0, idle);

      // Reset values.
      repeat (2) @(negedge clk);
      chkb("rst_v0", rsp0_valid, 1'b0);
      chkb("rst_v1", rsp1_valid, 1'b0);
      chk32("rst_res0", rsp0_result, 32'd0);
      chk32("rst_res1", rsp1_result, 32'd0);
      chk32("rst_tag0", 32'(rsp0_tag), 32'd0);
      chk32("rst_tag1", 32'(rsp1_tag), 32'd0);
      reset = 1'b0;

      // First transaction: ADD 5+7 tag 3.
      drive0(1'b1, '{ALU_ADD_SUB, 1'b0, 32'd5, 32'd7, TW'(3)});
      #1 chkb("first_rdy", req0_ready, 1'b1);
      @(negedge clk);
      chkb("first_v0", rsp0_valid, 1'b1);
      chkb("first_v1", rsp1_valid, 1'b0);
      chk32("first_res", rsp0_result, 32'd12);
      chk32("first_tag", 32'(rsp0_tag), 32'd3);

      // Vector table, one op per cycle on port 0.
      for (int i = 0; i < 12; i++) begin
         drive0(1'b1, '{vecs[i].f, vecs[i].m, vecs[i].a, vecs[i].b,
                        TW'(i)});
         @(negedge clk);
         chkb({"vec_v_", vecs[i].name}, rsp0_valid, 1'b1);
         chk32({"vec_", vecs[i].name}, rsp0_result, vecs[i].exp);
         chk32({"vec_tag_", vecs[i].name}, 32'(rsp0_tag), 32'(i));
      end
      drive0(1'b0, idle);
      @(negedge clk);

      // Reset while FULL drops the response immediately.
      rsp0_ready = 1'b0;
      drive0(1'b1, '{ALU_ADD_SUB, 1'b0, 32'd1, 32'd1, TW'(1)});
      @(negedge clk);
      drive0(1'b0, idle);
      chkb("full_v0", rsp0_valid, 1'b1);
      #2 reset = 1'b1;
      #1;
      chkb("async_rst_v0", rsp0_valid, 1'b0);
      chkb("async_rst_v1", rsp1_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      rsp0_ready = 1'b1;

      // Contention: grants alternate starting with port 0.
      drive0(1'b1, '{ALU_ADD_SUB, 1'b1, 32'd0, 32'd1, TW'(1)});
      drive1(1'b1, '{ALU_SRL_SRA, 1'b1, 32'h8000_0000, 32'd4, TW'(2)});
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_g = 1'b0;
`else
         exp_g = (i % 2) == 1;
`endif
         #1;
         chkb("alt_rdy0", req0_ready, !exp_g);
         chkb("alt_rdy1", req1_ready, exp_g);
         @(negedge clk);
         chkb("alt_v0", rsp0_valid, !exp_g);
         chkb("alt_v1", rsp1_valid, exp_g);
         if (exp_g) begin
            chk32("alt_res1", rsp1_result, 32'hF800_0000);
            chk32("alt_tag1", 32'(rsp1_tag), 32'd2);
         end else begin
            chk32("alt_res0", rsp0_result, 32'hFFFF_FFFF);
            chk32("alt_tag0", 32'(rsp0_tag), 32'd1);
         end
      end
      drive0(1'b0, idle);
      drive1(1'b0, idle);

      // Back-pressure on port 0 with port 1 waiting.
      rsp0_ready = 1'b0;
      drive0(1'b1, '{ALU_ADD_SUB, 1'b0, 32'd10, 32'd20, TW'(5)});
      #1 chkb("bp_acc", req0_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive0(1'b0, idle);
         drive1(1'b1, '{ALU_XOR, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F,
                        TW'(9)});
         #1;
         chkb("bp_rdy0", req0_ready, 1'b0);
         chkb("bp_rdy1", req1_ready, 1'b0);
         chkb("bp_v0", rsp0_valid, 1'b1);
         chk32("bp_res0", rsp0_result, 32'd30);
         chk32("bp_tag0", 32'(rsp0_tag), 32'd5);
      end
      rsp0_ready = 1'b1;
      #1 chkb("bp_release_rdy1", req1_ready, 1'b1);
      @(negedge clk);
      drive1(1'b0, idle);
      chkb("bp_next_v1", rsp1_valid, 1'b1);
      chkb("bp_next_v0", rsp0_valid, 1'b0);
      chk32("bp_next_res", rsp1_result, 32'hF00F_F00F);
      chk32("bp_next_tag", 32'(rsp1_tag), 32'd9);

      // Randomized traffic against the model.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_full = 0; m_own = 0; m_last = 1;
      m_res = '0; m_tag = '0;
      hold0 = 0; hold1 = 0; v0 = 0; v1 = 0;
      r0 = idle; r1 = idle;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         chkb("rnd_v0", rsp0_valid, m_full && !m_own);
         chkb("rnd_v1", rsp1_valid, m_full && m_own);
         if (m_full) begin
            xr = m_own ? rsp1_result : rsp0_result;
            chk32("rnd_res", xr, m_res);
            chk32("rnd_tag", 32'(m_own ? rsp1_tag : rsp0_tag),
                  32'(m_tag));
         end
         if (!hold0) begin
            v0 = $urandom_range(0, 2) != 0;
            r0 = rand_req();
         end
         if (!hold1) begin
            v1 = $urandom_range(0, 2) != 0;
            r1 = rand_req();
         end
         rr0 = $urandom_range(0, 3) != 0;
         rr1 = $urandom_range(0, 3) != 0;
         drive0(v0, r0);
         drive1(v1, r1);
         rsp0_ready = rr0;
         rsp1_ready = rr1;
         #1;
         mfree = !m_full || (m_own ? rr1 : rr0);
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_g = !v0 && v1;
`else
         if (v0 && v1) exp_g = !m_last;
         else          exp_g = v1;
`endif
         acc0 = mfree && v0 && !exp_g;
         acc1 = mfree && v1 && exp_g;
         if (v0) chkb("rnd_rdy0", req0_ready, acc0);
         if (v1) chkb("rnd_rdy1", req1_ready, acc1);
         if (acc0 || acc1) begin
            m_full = 1;
            m_own  = exp_g;
            m_last = exp_g;
            if (exp_g) begin
               m_res = ref_alu(r1.f, r1.m, r1.a, r1.b);
               m_tag = r1.tag;
            end else begin
               m_res = ref_alu(r0.f, r0.m, r0.a, r0.b);
               m_tag = r0.tag;
            end
         end else if (mfree) begin
            m_full = 0;
         end
         hold0 = v0 && !acc0;
         hold1 = v1 && !acc1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between two requesters, typically the execute stage (port 0) and an auxiliary unit such as CSR or address generation (port 1). It accepts operations over valid/ready request channels and arbitrates between them round-robin. Results are registered in a single-entry buffer and returned on per-requester response channels.

## Interface
Parameters:
- `TAG_WIDTH`, default 4: width of the opaque tag carried from request to response.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_function_select` / `req1_...`  in  3  ALU operation; `ALU_*` encodings.
- `req0_function_modifier` / `req1_...`  in  1  selects SUB, SRA or CLR.
- `req0_input_a`, `req0_input_b` / `req1_...`  in  32 each  operands.
- `req0_tag` / `req1_tag`  in  TAG_WIDTH  returned unchanged with the result.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes the result.
- `rsp0_result` / `rsp1_result`  out  32  registered ALU result.
- `rsp0_tag` / `rsp1_tag`  out  TAG_WIDTH  tag of the buffered operation.

## Operation
- State machine: EMPTY (buffer free) and FULL (buffer holds a result for `owner`).
- Slot availability: `free = (state==EMPTY) || (rspN_valid && rspN_ready for N==owner)`.
- Grant (combinational, only when `free`):
  - Exactly one `reqN_valid`: grant N.
  - Both valid: grant the requester not equal to `last_grant`.
- `reqN_ready = free && grant==N`. Ready may depend on valid. A requester must hold its valid and payload stable until ready.
- On accept (`reqN_valid && reqN_ready`):
  - The ALU evaluates the granted operands in the same cycle.
  - Result, tag and `owner=N` are registered.
  - `last_grant` becomes N and the state becomes FULL.
- In FULL, `rsp{owner}_valid=1` and the other `rspM_valid=0`. `rspM_result` and `rspM_tag` mirror the buffer on both ports; they are meaningful only when that port's valid is high.
- Consume without a new accept: FULL→EMPTY. Consume with a new accept in the same cycle: stays FULL with the new contents.
- ALU semantics, all 32-bit results:
  - ADD/SUB wraps mod 2^32.
  - Shifts use `input_b[4:0]` only.
  - SLT is signed and SLTU unsigned; both return 0 or 1.
  - AND_CLR with the modifier set returns `~a & b`.
- Reset mid-operation discards the buffered result with no response. A requester whose result is discarded must reissue the operation.

## Timing
- Reset values:
  - State EMPTY; both `rspN_valid` 0.
  - `rspN_result` 0 and `rspN_tag` 0.
  - `owner` 0 and `last_grant` 1, so port 0 wins the first contention.
- Latency: accept in cycle N gives `rsp_valid` in cycle N+1.
- Throughput: one operation per cycle while the owner holds `rsp_ready` high.
- Back-pressure: while FULL and not consumed, both `reqN_ready` are 0. The buffer and outputs hold stable.
- No combinational path from `req*` inputs to `rsp*` outputs. There is a combinational path from `rsp_ready` to `req_ready`.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Port 0 always wins contention and `last_grant` is not implemented.
  - Port 1 can starve; this is acceptable when port 1 is low-rate.
- Macro undefined: round-robin as specified above.

## Structure
- Shared package / `params.vh`:
  - `ALU_*` function-select constants (ADD_SUB=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL_SRA=5, OR=6, AND_CLR=7).
  - State encoding constants EMPTY/FULL.
- One sub-module: the existing `alu` unit, instantiated once. The arbiter drives its operands through a grant-selected mux.

## Test plan
- After reset: req0 ADD a=5, b=7, tag=3 → `req0_ready` same cycle; next cycle `rsp0_valid=1`, result 12, tag 3, `rsp1_valid=0`.
- Both valid every cycle with `rsp*_ready=1`: req0 SUB 0−1, req1 SRA 0x80000000>>4 → grants alternate 0,1,0,1. Results 0xFFFFFFFF and 0xF8000000 on the matching ports. With `ALU_ARB_FIXED_PRIO_EN`, only port 0 is granted.
- Back-pressure: result held with `rsp0_ready=0` for 3 cycles → both req ready 0, output stable. Ready rises with req1 pending → req1 accepted the same cycle; its result appears next cycle.
- Edge operands:
  - SLT 0xFFFFFFFF < 1 → 1; SLTU of the same operands → 0.
  - SLL by b=33 → shift by 1.
  - AND_CLR with modifier, a=0xF0, b=0xFF → 0x0F.
  - ADD 0xFFFFFFFF+1 → 0.
- Reset asserted while FULL → `rsp*_valid` 0 immediately (asynchronous); the next grant after reset goes to port 0.
